// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer and pulse generator for
// active-low push buttons.
//
// Each channel turns a raw button into a debounced held level plus one-cycle
// press and release pulses. Compile-time option KEY_LONG_PRESS_EN adds a
// one-cycle long-press pulse. Without it, key_long is tied low and the counter
// is only as wide as the debounce count needs.
//
// Handshake note: there is no valid/ready flow here. Every output is a
// registered level or a single-cycle strobe that is meaningful on every clock.
module key_conditioner #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  // The counter only has to reach the long-press threshold when that feature
  // is built in. Otherwise the debounce count sets its width.
  localparam int MAX_CNT = (LONG_EN != 0 && LONG_CYCLES > DEBOUNCE_CYCLES) ?
                           LONG_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  // The count is compared before it increments, so "reached N" means the
  // current value is N-1 on the edge that accepts the change.
  localparam logic [CW-1:0] DEB_END = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_END = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] LONG_SAT = CW'(LONG_CYCLES);
`endif

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    logic [1:0]    sync_q;
    logic          p;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;
    logic          rel_q;

    // Two-flop synchroniser. It resets to "released" so that a key held
    // through reset is seen as a fresh press.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync_q <= 2'b11;
      end else begin
        sync_q <= {sync_q[0], key_n[g]};
      end
    end

    assign p = ~sync_q[1];

`ifdef KEY_LONG_PRESS_EN
    logic long_q;
    logic fired_q;
`endif

    // Debounce FSM with registered level and pulse outputs.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_q  <= 1'b0;
        fired_q <= 1'b0;
`endif
      end else begin
        press_q <= 1'b0;
        rel_q   <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
        long_q  <= 1'b0;
`endif
        case (state_q)
          IDLE: begin
            if (p) begin
              state_q <= PRESS_WAIT;
              cnt_q   <= CNT_ONE;
            end else begin
              cnt_q   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!p) begin
              // A glitch shorter than the debounce window is dropped silently.
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_END) begin
              state_q <= HELD;
              cnt_q   <= '0;
              press_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end
          HELD: begin
            if (!p) begin
              state_q <= RELEASE_WAIT;
              cnt_q   <= CNT_ONE;
            end else begin
`ifdef KEY_LONG_PRESS_EN
              // Count held time, saturating. The pulse fires once per press.
              if (cnt_q != LONG_SAT) begin
                cnt_q <= cnt_q + CNT_ONE;
                if (cnt_q == LONG_END && !fired_q) begin
                  long_q  <= 1'b1;
                  fired_q <= 1'b1;
                end
              end
`else
              cnt_q <= '0;
`endif
            end
          end
          RELEASE_WAIT: begin
            if (p) begin
              // A release bounce: back to held. The long-press time restarts,
              // but a long pulse already given for this press stays suppressed.
              state_q <= HELD;
              cnt_q   <= '0;
            end else if (cnt_q == DEB_END) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              rel_q   <= 1'b1;
              level_q <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
              fired_q <= 1'b0;
`endif
            end else begin
              cnt_q   <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = rel_q;
`ifdef KEY_LONG_PRESS_EN
    assign key_long[g]    = long_q;
`else
    assign key_long[g]    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with DEBOUNCE_CYCLES=8 and LONG_CYCLES=20.
// The reference model works on run lengths of the synchronised key. A change
// is accepted after D consecutive opposite samples. A long press fires when the
// held time since the later of press acceptance or the last release bounce
// reaches L. Honours KEY_LONG_PRESS_EN the same way the design does.
module tb_key_conditioner;
  localparam int NK = 4;
  localparam int D  = 8;
  localparam int L  = 20;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] key_level, key_press, key_release, key_long;

  key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rstn(rstn), .key_n(key_n),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  // Clock.
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [NK-1:0] exp_level, exp_press, exp_release, exp_long;
  logic [NK-1:0] m_s1, m_s2;
  int            m_ones[NK], m_zeros[NK], m_press_t[NK];
  bit            m_fired[NK];
  int            m_t;

  task automatic model_reset();
    exp_level = '0; exp_press = '0; exp_release = '0; exp_long = '0;
    m_s1 = '1; m_s2 = '1; m_t = 0;
    for (int k = 0; k < NK; k++) begin
      m_ones[k] = 0; m_zeros[k] = 0; m_press_t[k] = 0; m_fired[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit p;
    int anchor;
    m_t++;
    exp_press = '0; exp_release = '0; exp_long = '0;
    for (int k = 0; k < NK; k++) begin
      p = !m_s2[k];
      if (p) begin m_ones[k]++; m_zeros[k] = 0; end
      else begin m_zeros[k]++; m_ones[k] = 0; end
      if (!exp_level[k] && m_ones[k] >= D) begin
        exp_press[k] = 1'b1; exp_level[k] = 1'b1; m_press_t[k] = m_t;
      end else if (exp_level[k] && m_zeros[k] >= D) begin
        exp_release[k] = 1'b1; exp_level[k] = 1'b0; m_fired[k] = 1'b0;
      end else if (LONG_EN && exp_level[k] && p && !m_fired[k]) begin
        anchor = m_t - m_ones[k] + 1;
        if (m_press_t[k] > anchor) anchor = m_press_t[k];
        if (m_t - anchor == L) begin
          exp_long[k] = 1'b1; m_fired[k] = 1'b1;
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = key_n;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // ---------------- compare process + pulse counters ----------------
  int press_cnt[NK], rel_cnt[NK], long_cnt[NK];

  initial begin
    logic [4*NK-1:0] act, exp;
    forever begin
      @(negedge clk);
      act = {key_level, key_press, key_release, key_long};
      exp = rstn ? {exp_level, exp_press, exp_release, exp_long} : '0;
      check("outputs_vs_model", 32'(act), 32'(exp));
      if (rstn) begin
        for (int k = 0; k < NK; k++) begin
          press_cnt[k] += int'(key_press[k]);
          rel_cnt[k]   += int'(key_release[k]);
          long_cnt[k]  += int'(key_long[k]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
    end
  endtask

  // Counts rising edges until the chosen pulse is seen (0 press, 1 release,
  // 2 long); returns -1 if the budget runs out.
  task automatic wait_pulse(input int k, input int which, input int budget, output int n);
    bit found;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      case (which)
        0:       found = key_press[k];
        1:       found = key_release[k];
        default: found = key_long[k];
      endcase
    end
    if (!found) n = -1;
  endtask

  // ---------------- stimulus ----------------
  int n;
  int hold[NK];

  initial begin
    // 1. reset then idle
    clear_counts();
    tick(3);
    rstn = 1'b1;
    tick(100);
    check("idle_presses", 32'(press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3]), 0);
    check("idle_level", 32'(key_level), 0);

    // 2. clean press on key 0
    clear_counts();
    key_n[0] = 1'b0;
    wait_pulse(0, 0, 30, n);
    check("press_latency_k0", 32'(n), 10);
    check("level_after_press_k0", 32'(key_level[0]), 1);
`ifdef KEY_LONG_PRESS_EN
    wait_pulse(0, 2, 40, n);
    check("long_latency_k0", 32'(n), 20);
`endif
    tick(35);
    key_n[0] = 1'b1;
    wait_pulse(0, 1, 30, n);
    check("release_latency_k0", 32'(n), 10);
    check("level_after_release_k0", 32'(key_level[0]), 0);
    tick(5);
    check("press_count_k0", 32'(press_cnt[0]), 1);
    check("long_count_k0", 32'(long_cnt[0]), LONG_EN ? 1 : 0);

    // 3. press bounce on key 1
    clear_counts();
    key_n[1] = 1'b0; tick(5);
    key_n[1] = 1'b1; tick(2);
    key_n[1] = 1'b0; tick(5);
    key_n[1] = 1'b1; tick(15);
    check("bounce_no_press_k1", 32'(press_cnt[1]), 0);
    check("bounce_level_k1", 32'(key_level[1]), 0);
    key_n[1] = 1'b0; tick(12);
    key_n[1] = 1'b1; tick(20);
    check("bounce_then_press_k1", 32'(press_cnt[1]), 1);
    check("bounce_then_release_k1", 32'(rel_cnt[1]), 1);

    // 4. release bounce on key 2
    clear_counts();
    key_n[2] = 1'b0; tick(15);
    key_n[2] = 1'b1; tick(3);
    key_n[2] = 1'b0; tick(20);
    check("rel_bounce_no_release_k2", 32'(rel_cnt[2]), 0);
    check("rel_bounce_one_press_k2", 32'(press_cnt[2]), 1);
    check("rel_bounce_level_k2", 32'(key_level[2]), 1);
    key_n[2] = 1'b1; tick(15);
    check("rel_bounce_final_release_k2", 32'(rel_cnt[2]), 1);

    // 5. simultaneous press on keys 0 and 3
    clear_counts();
    key_n = 4'b0110;
    wait_pulse(0, 0, 30, n);
    check("simul_latency", 32'(n), 10);
    check("simul_press_bits", 32'(key_press), 32'h9);
    tick(5);
    key_n = 4'b1111;
    tick(15);
    check("simul_release_k3", 32'(rel_cnt[3]), 1);

    // 6. reset while key 1 is held
    clear_counts();
    key_n[1] = 1'b0;
    wait_pulse(1, 0, 30, n);
    tick(3);
    rstn = 1'b0;
    #1;
    check("reset_clears_outputs", 32'({key_level, key_press, key_release, key_long}), 0);
    tick(3);
    rstn = 1'b1;
    wait_pulse(1, 0, 30, n);
    check("press_after_reset_k1", 32'(n), 10);
    key_n[1] = 1'b1;
    tick(15);

    // Randomised phase: independent random hold times, occasional reset.
    for (int k = 0; k < NK; k++) hold[k] = $urandom_range(1, 20);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_n[k] = ~key_n[k];
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : $urandom_range(8, 60);
        end else begin
          hold[k]--;
        end
      end
      if ($urandom_range(0, 699) == 0) begin
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
      end
      tick(1);
    end
    key_n = '1;
    tick(30);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
